pwm_reg_ctrl: RTL and testbench
===============================

PWM_REG_CTRL -- requirements
Module: pwm_reg_ctrl

Interface
REQ-001 SHALL have the following ports, in this order:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- spi_wr_en  in  1  write strobe from the SPI slave, in the SCLK domain, asynchronous to clk
- spi_addr  in  2  register address from the SPI slave
- spi_data  in  8  write data from the SPI slave
- rd_data  out  8  register read-back to the SPI slave
- pwm_out  out  1  PWM output
- period_done  out  1  one-clk pulse at each period wrap
REQ-002 SHALL have the following parameter:
- SYNC_STAGES, default 2, number of synchronizer flops on spi_wr_en (legal values 2..3).

Function
REQ-003 SHALL pass spi_wr_en through SYNC_STAGES flops, then rising-edge detect it into a one-clk wr_stb.
REQ-004 SHALL capture spi_addr and spi_data on the wr_stb cycle and write the register at that address on the next edge; system SHALL hold CS low >= SYNC_STAGES+2 clk after the last SCLK edge.
REQ-005 SHALL implement the register map:
- 0 CTRL: bit0 enable, bit1 invert, bits7:2 read as 0
- 1 PRESCALE
- 2 PERIOD
- 3 DUTY
REQ-006 SHALL drive rd_data combinationally with the register selected by spi_addr (programmed values, not shadows).
REQ-007 SHALL run an FSM with states OFF and RUN; OFF->RUN when CTRL.enable=1; RUN->OFF when CTRL.enable=0 (next edge).
REQ-008 In OFF, prescale and period counters SHALL be 0, pwm_out 0 (invert ignored), period_done 0.
REQ-009 In RUN, the prescale counter SHALL count 0..PRESCALE and wrap; tick SHALL assert on the wrap cycle (PRESCALE=0 gives a tick every clk).
REQ-010 On tick the period counter SHALL increment and wrap PERIOD->0; period_done SHALL pulse on the tick where the period counter wraps.
REQ-011 Raw PWM SHALL be 1 when period counter < active duty; pwm_out = raw XOR CTRL.invert, registered (1 clk latency).
REQ-012 Boundaries:
- DUTY=0: always low.
- DUTY>PERIOD: always high.
- PERIOD=0: period of one tick, period_done on every tick.
REQ-013 A write to CTRL with enable=0 mid-period SHALL enter OFF immediately; re-enable SHALL start from counter 0.
REQ-014 Simultaneous wr_stb and period wrap SHALL apply the new value per REQ-016/017; no write is lost.

Reset
REQ-015 On rst_n low, SHALL asynchronously clear all registers, shadows, counters, synchronizer flops, wr_stb, pwm_out and period_done, and enter FSM state OFF.

Configuration
REQ-016 With PWM_SHADOW_EN defined, PERIOD, DUTY and PRESCALE SHALL load into shadow registers at period wrap (and on OFF->RUN); counters SHALL use the shadows.
REQ-017 Without PWM_SHADOW_EN, counters SHALL use the programmed registers directly; writes take effect the next clk.

Structure
REQ-018 A shared package SHALL hold:
- register address constants ADDR_CTRL=0, ADDR_PRESCALE=1, ADDR_PERIOD=2, ADDR_DUTY=3
- CTRL bit indices
- FSM state encoding (OFF=0, RUN=1)
REQ-019 The synchronizer plus edge detector SHALL be sub-module pulse_sync (parameter SYNC_STAGES).

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset: rst_n low mid-run -> pwm_out=0, period_done=0, rd_data=0 for all addresses.
- Basic PWM: PRESCALE=0, PERIOD=9, DUTY=3, CTRL=1 -> pwm_out high 3 clk, low 7 clk, repeating; period_done every 10 clk.
- Invert and boundaries: CTRL=3, DUTY=0 -> pwm_out constantly 1; DUTY=20, PERIOD=9, CTRL=1 -> constantly 1.
- Prescale: PRESCALE=3, PERIOD=4, DUTY=2 -> high 8 clk, low 12 clk; period_done every 20 clk.
- Shadow: with PWM_SHADOW_EN, DUTY changes 3->7 mid-period -> new duty first seen after the next period_done; without the macro -> visible within 2 clk.
- CDC: spi_wr_en pulse asynchronous to clk, addr=2, data=0x55 -> rd_data at addr 2 = 0x55 within SYNC_STAGES+3 clk; exactly one write per pulse.

Source files
------------

// File: rtl/pwm_reg_ctrl_pkg.sv
// Shared definitions for the SPI-programmed PWM block: register map,
// CTRL bit positions and the OFF/RUN state encoding.
package pwm_reg_ctrl_pkg;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_PRESCALE = 2'd1;
  localparam logic [1:0] ADDR_PERIOD   = 2'd2;
  localparam logic [1:0] ADDR_DUTY     = 2'd3;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_INVERT_BIT = 1;

  typedef enum logic {
    OFF = 1'b0,
    RUN = 1'b1
  } pwm_state_e;

  // CTRL read-back: only enable and invert are implemented, upper bits read 0.
  function automatic logic [7:0] ctrl_readback(input logic enable, input logic invert);
    logic [7:0] value;
    value = '0;
    value[CTRL_ENABLE_BIT] = enable;
    value[CTRL_INVERT_BIT] = invert;
    return value;
  endfunction

endpackage

// File: rtl/pwm_reg_ctrl_pulse_sync.sv
// Multi-flop synchronizer for an asynchronous level, followed by a
// rising-edge detector producing a registered one-clk pulse.
module pulse_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_level,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev   <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_level};
      prev   <= sync_q[SYNC_STAGES-1];
      pulse  <= sync_q[SYNC_STAGES-1] & ~prev;
    end
  end

endmodule

// File: rtl/pwm_reg_ctrl.sv
// PWM generator with an SPI-written register file (CTRL/PRESCALE/PERIOD/DUTY).
// Define PWM_SHADOW_EN to make PRESCALE/PERIOD/DUTY take effect only at period wrap.
module pwm_reg_ctrl
  import pwm_reg_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_wr_en,
  input  logic [1:0] spi_addr,
  input  logic [7:0] spi_data,
  output logic [7:0] rd_data,
  output logic       pwm_out,
  output logic       period_done
);

  logic       wr_stb;
  logic       vld_p0;
  logic [1:0] wr_addr_p0;
  logic [7:0] wr_data_p0;

  logic       ctrl_enable;
  logic       ctrl_invert;
  logic [7:0] prescale_reg;
  logic [7:0] period_reg;
  logic [7:0] duty_reg;

  logic       wr_ctrl;
  logic       wr_prescale;
  logic       wr_period;
  logic       wr_duty;

  logic [7:0] act_prescale;
  logic [7:0] act_period;
  logic [7:0] act_duty;

  pwm_state_e state;
  pwm_state_e state_next;
  logic       run_active;

  logic [7:0] pre_cnt;
  logic [7:0] per_cnt;
  logic       tick;
  logic       per_wrap;

  pulse_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pulse_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_level(spi_wr_en),
    .pulse      (wr_stb)
  );

  // Stage p0: capture SPI address/data while the strobe is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0     <= 1'b0;
      wr_addr_p0 <= '0;
      wr_data_p0 <= '0;
    end else begin
      vld_p0 <= wr_stb;
      if (wr_stb) begin
        wr_addr_p0 <= spi_addr;
        wr_data_p0 <= spi_data;
      end
    end
  end

  assign wr_ctrl     = vld_p0 && (wr_addr_p0 == ADDR_CTRL);
  assign wr_prescale = vld_p0 && (wr_addr_p0 == ADDR_PRESCALE);
  assign wr_period   = vld_p0 && (wr_addr_p0 == ADDR_PERIOD);
  assign wr_duty     = vld_p0 && (wr_addr_p0 == ADDR_DUTY);

  // Stage p1: register file update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_enable  <= 1'b0;
      ctrl_invert  <= 1'b0;
      prescale_reg <= '0;
      period_reg   <= '0;
      duty_reg     <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_enable <= wr_data_p0[CTRL_ENABLE_BIT];
        ctrl_invert <= wr_data_p0[CTRL_INVERT_BIT];
      end
      if (wr_prescale) prescale_reg <= wr_data_p0;
      if (wr_period)   period_reg   <= wr_data_p0;
      if (wr_duty)     duty_reg     <= wr_data_p0;
    end
  end

  always_comb begin
    rd_data = '0;
    case (spi_addr)
      ADDR_CTRL:     rd_data = ctrl_readback(ctrl_enable, ctrl_invert);
      ADDR_PRESCALE: rd_data = prescale_reg;
      ADDR_PERIOD:   rd_data = period_reg;
      ADDR_DUTY:     rd_data = duty_reg;
      default:       rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OFF;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      OFF:     if (ctrl_enable)  state_next = RUN;
      RUN:     if (!ctrl_enable) state_next = OFF;
      default: state_next = OFF;
    endcase
  end

  // A disable takes hold in the same cycle CTRL changes, before the state flips.
  assign run_active = (state == RUN) && ctrl_enable;

  assign tick     = (pre_cnt >= act_prescale);
  assign per_wrap = tick && (per_cnt >= act_period);

`ifdef PWM_SHADOW_EN
  logic [7:0] sh_prescale;
  logic [7:0] sh_period;
  logic [7:0] sh_duty;
  logic       load_shadow;

  // A write landing on the wrap edge is forwarded so it is not deferred a period.
  assign load_shadow = (state == OFF) || (run_active && per_wrap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_prescale <= '0;
      sh_period   <= '0;
      sh_duty     <= '0;
    end else if (load_shadow) begin
      sh_prescale <= wr_prescale ? wr_data_p0 : prescale_reg;
      sh_period   <= wr_period   ? wr_data_p0 : period_reg;
      sh_duty     <= wr_duty     ? wr_data_p0 : duty_reg;
    end
  end

  assign act_prescale = sh_prescale;
  assign act_period   = sh_period;
  assign act_duty     = sh_duty;
`else
  assign act_prescale = prescale_reg;
  assign act_period   = period_reg;
  assign act_duty     = duty_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      per_cnt <= '0;
    end else if (!run_active) begin
      pre_cnt <= '0;
      per_cnt <= '0;
    end else begin
      pre_cnt <= tick ? 8'd0 : pre_cnt + 8'd1;
      if (tick) begin
        per_cnt <= per_wrap ? 8'd0 : per_cnt + 8'd1;
      end
    end
  end

  // Stage p2: registered PWM and wrap pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
    end else begin
      pwm_out     <= run_active && ((per_cnt < act_duty) ^ ctrl_invert);
      period_done <= run_active && per_wrap;
    end
  end

endmodule

// File: tb/tb_pwm_reg_ctrl.sv
// Randomized bench for pwm_reg_ctrl against a period/duty arithmetic model.
module tb_pwm_reg_ctrl;

  localparam int SYNC_STAGES = 2;
  localparam int WR_LAT      = SYNC_STAGES + 3;

  logic       clk;
  logic       rst_n;
  logic       spi_wr_en;
  logic [1:0] spi_addr;
  logic [7:0] spi_data;
  logic [7:0] rd_data;
  logic       pwm_out;
  logic       period_done;

  int checks = 0;
  int errors = 0;

  pwm_reg_ctrl #(
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_wr_en  (spi_wr_en),
    .spi_addr   (spi_addr),
    .spi_data   (spi_data),
    .rd_data    (rd_data),
    .pwm_out    (pwm_out),
    .period_done(period_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cycle n after enable: tick length L, full period T, output high while tick index < duty.
  function automatic void model(input int ps, input int per, input int duty, input int inv,
                                input int n, output logic p, output logic d);
    int len;
    int tot;
    int pos;
    len = ps + 1;
    tot = (per + 1) * len;
    pos = n % tot;
    p = (((pos / len) < duty) ? 1'b1 : 1'b0) ^ inv[0];
    d = (pos == tot - 1);
  endfunction

  // Raises spi_wr_en at a random phase and reports the clk edge the write became visible.
  task automatic spi_write(input logic [1:0] addr, input logic [7:0] data, input int idle,
                           output int seen_at);
    logic [7:0] exp;
    exp = (addr == 2'd0) ? (data & 8'h03) : data;
    repeat (idle) @(posedge clk);
    #($urandom_range(1, 7));
    spi_addr  = addr;
    spi_data  = data;
    spi_wr_en = 1'b1;
    seen_at   = 0;
    for (int k = 1; k <= WR_LAT; k++) begin
      @(posedge clk);
      #1;
      if (seen_at == 0 && rd_data == exp) seen_at = k;
    end
    spi_wr_en = 1'b0;
    check("wr_readback", rd_data, exp);
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(posedge clk);
      #1;
      if (period_done) ok = 1'b1;
    end
  endtask

  task automatic run_case(input int ps, input int per, input int duty, input int inv,
                          input int ncyc);
    int   seen;
    logic ep;
    logic ed;
    spi_write(2'd0, 8'h00, SYNC_STAGES + 2, seen);
    @(posedge clk);
    #1;
    check("off_pwm", pwm_out, 1'b0);
    check("off_done", period_done, 1'b0);
    spi_write(2'd1, ps[7:0], SYNC_STAGES + 2, seen);
    spi_write(2'd2, per[7:0], SYNC_STAGES + 2, seen);
    spi_write(2'd3, duty[7:0], SYNC_STAGES + 2, seen);
    spi_write(2'd0, {6'd0, inv[0], 1'b1}, SYNC_STAGES + 2, seen);
    check("en_latency", seen, WR_LAT);
    @(posedge clk);
    for (int n = 0; n < ncyc; n++) begin
      @(posedge clk);
      #1;
      model(ps, per, duty, inv, n, ep, ed);
      check("pwm", pwm_out, ep);
      check("done", period_done, ed);
    end
  endtask

  initial begin
    int  seen;
    bit  ok;
    int  highs;
    int  ps, per, duty, inv;

    rst_n     = 1'b0;
    spi_wr_en = 1'b0;
    spi_addr  = 2'd0;
    spi_data  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pwm", pwm_out, 1'b0);
    check("rst_done", period_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_case(0, 9, 3, 0, 30);
    run_case(0, 9, 0, 1, 20);
    run_case(0, 9, 20, 0, 20);
    run_case(3, 4, 2, 0, 40);
    run_case(1, 0, 1, 0, 10);

    // Duty change mid-period while running 3-of-10
    run_case(0, 9, 3, 0, 12);
    wait_done(40, ok);
    check("shadow_wait1", ok, 1'b1);
    spi_write(2'd3, 8'd7, 0, seen);
    @(posedge clk);
    #1;
`ifdef PWM_SHADOW_EN
    check("duty_deferred", pwm_out, 1'b0);
`else
    check("duty_now", pwm_out, 1'b1);
`endif
    wait_done(40, ok);
    check("shadow_wait2", ok, 1'b1);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      highs += int'(pwm_out);
    end
    check("duty_new_highs", highs, 7);

    // One asynchronous pulse writes exactly once
    spi_write(2'd2, 8'h55, SYNC_STAGES + 2, seen);
    check("cdc_seen", (seen != 0 && seen <= WR_LAT), 1'b1);
    spi_data = 8'hAA;
    repeat (WR_LAT + 2) @(posedge clk);
    #1;
    check("cdc_single", rd_data, 8'h55);

    for (int it = 0; it < 8; it++) begin
      ps   = $urandom_range(0, 3);
      per  = $urandom_range(0, 12);
      duty = $urandom_range(0, 15);
      inv  = $urandom_range(0, 1);
      run_case(ps, per, duty, inv, 2 * (per + 1) * (ps + 1) + 5);
    end

    // Asynchronous reset mid-run
    run_case(1, 6, 3, 1, 9);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_run_pwm", pwm_out, 1'b0);
    check("rst_run_done", period_done, 1'b0);
    for (int a = 0; a < 4; a++) begin
      spi_addr = a[1:0];
      #1;
      check("rst_rd", rd_data, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_pwm", pwm_out, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
